// File: rtl/wasm_stack_ctrl_pkg.sv
// Shared opcode, trap-code and FSM state definitions for the wasm stack controller.
package wasm_stack_pkg;

    localparam logic [3:0] OP_NOP  = 4'd0;
    localparam logic [3:0] OP_PUSH = 4'd1;
    localparam logic [3:0] OP_DROP = 4'd2;
    localparam logic [3:0] OP_DUP  = 4'd3;
    localparam logic [3:0] OP_SWAP = 4'd4;
    localparam logic [3:0] OP_ADD  = 4'd5;
    localparam logic [3:0] OP_SUB  = 4'd6;
    localparam logic [3:0] OP_EQZ  = 4'd7;
    localparam logic [3:0] OP_AND  = 4'd8;
    localparam logic [3:0] OP_OR   = 4'd9;
    localparam logic [3:0] OP_XOR  = 4'd10;

    localparam logic [1:0] TRAP_NONE      = 2'd0;
    localparam logic [1:0] TRAP_UNDERFLOW = 2'd1;
    localparam logic [1:0] TRAP_OVERFLOW  = 2'd2;
    localparam logic [1:0] TRAP_ILLEGAL   = 2'd3;

    typedef enum logic [3:0] {
        IDLE, CHECK, RD2, WAIT2, POP, WR2, WRTOP, PUSH, SETTLE, RESP
    } state_t;

    function automatic logic is_binary(input logic [3:0] op);
        return op inside {OP_ADD, OP_SUB, OP_AND, OP_OR, OP_XOR};
    endfunction

endpackage

// File: rtl/wasm_stack_ctrl_if.sv
// Command/response handshake bundle between a host and the wasm stack controller.
interface wasm_stack_ctrl_if #(parameter int WIDTH = 32);
    logic             cmd_valid;
    logic             cmd_ready;
    logic [3:0]       cmd_op;
    logic [WIDTH-1:0] cmd_imm;
    logic             rsp_valid;
    logic             rsp_ready;
    logic [WIDTH-1:0] rsp_data;
    logic             trap;
    logic [1:0]       trap_code;

    modport master (
        output cmd_valid, cmd_op, cmd_imm, rsp_ready,
        input  cmd_ready, rsp_valid, rsp_data, trap, trap_code
    );
    modport slave (
        input  cmd_valid, cmd_op, cmd_imm, rsp_ready,
        output cmd_ready, rsp_valid, rsp_data, trap, trap_code
    );
endinterface

// File: rtl/wasm_stack.sv
// Register-file operand stack driven by wasm_stack_ctrl; depth wraps modulo 2**DEPTH_LOG2.
module wasm_stack #(
    parameter int DEPTH_LOG2 = 5,
    parameter int WIDTH      = 32
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  push,
    input  logic                  pop,
    input  logic                  read_second,
    input  logic                  write_top,
    input  logic                  write_second,
    input  logic [WIDTH-1:0]      push_data,
    input  logic [WIDTH-1:0]      write_data,
    output logic [WIDTH-1:0]      top_data,
    output logic [WIDTH-1:0]      second_data,
    output logic [DEPTH_LOG2-1:0] depth
);

    logic [WIDTH-1:0]      mem [2**DEPTH_LOG2];
    logic [DEPTH_LOG2-1:0] top_idx;
    logic [DEPTH_LOG2-1:0] sec_idx;

    assign top_idx  = depth - DEPTH_LOG2'(1);
    assign sec_idx  = depth - DEPTH_LOG2'(2);
    assign top_data = mem[top_idx];

    // second_data is a registered read, valid the cycle after read_second
    always_ff @(posedge clk) begin
        if (reset) begin
            depth       <= '0;
            second_data <= '0;
        end else begin
            if (push)        depth       <= depth + DEPTH_LOG2'(1);
            if (pop)         depth       <= depth - DEPTH_LOG2'(1);
            if (read_second) second_data <= mem[sec_idx];
        end
    end

    always_ff @(posedge clk) begin
        if (!reset) begin
            if (push)         mem[depth]   <= push_data;
            if (write_top)    mem[top_idx] <= write_data;
            if (write_second) mem[sec_idx] <= write_data;
        end
    end

endmodule

// File: rtl/wasm_stack_alu.sv
// Combinational datapath for the arithmetic/logic opcodes; a is the deeper operand.
module wasm_stack_alu
    import wasm_stack_pkg::*;
#(
    parameter int WIDTH = 32
) (
    input  logic [3:0]       op,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    output logic [WIDTH-1:0] result
);

    always_comb begin
        result = '0;
        case (op)
            OP_ADD:  result = a + b;
            OP_SUB:  result = a - b;
            OP_EQZ:  result = {{(WIDTH-1){1'b0}}, (a == '0)};
            OP_AND:  result = a & b;
            OP_OR:   result = a | b;
            OP_XOR:  result = a ^ b;
            default: result = '0;
        endcase
    end

endmodule

// File: rtl/wasm_stack_ctrl.sv
// Sequencer turning wasm stack opcodes into one-strobe-per-cycle stack accesses.
// Define WASM_STACK_TRAP_EN to trap on stack underflow/overflow in CHECK.
module wasm_stack_ctrl
    import wasm_stack_pkg::*;
#(
    parameter int DEPTH_LOG2 = 5,
    parameter int WIDTH      = 32
) (
    input  logic                  clk,
    input  logic                  reset,
    wasm_stack_ctrl_if.slave      bus,
    output logic                  stk_push,
    output logic                  stk_pop,
    output logic                  stk_read_second,
    output logic                  stk_write_top,
    output logic                  stk_write_second,
    output logic [WIDTH-1:0]      stk_push_data,
    output logic [WIDTH-1:0]      stk_write_data,
    input  logic [WIDTH-1:0]      stk_top_data,
    input  logic [WIDTH-1:0]      stk_second_data,
    input  logic [DEPTH_LOG2-1:0] stk_depth
);

    state_t           state;
    logic [3:0]       op_q;
    logic [WIDTH-1:0] imm_q, a_q, b_q;
    logic             rsp_valid_q, trap_q;
    logic [WIDTH-1:0] rsp_data_q;
    logic [1:0]       trap_code_q;
    logic [WIDTH-1:0] alu_a, alu_res, rsp_top;

    assign bus.cmd_ready = (state == IDLE) && !reset;
    assign bus.rsp_valid = rsp_valid_q;
    assign bus.rsp_data  = rsp_data_q;
    assign bus.trap      = trap_q;
    assign bus.trap_code = trap_code_q;

    // EQZ evaluates straight off the live top in CHECK; binary ops use latched operands
    assign alu_a   = (state == CHECK) ? stk_top_data : a_q;
    assign rsp_top = (stk_depth == '0) ? '0 : stk_top_data;

    wasm_stack_alu #(.WIDTH(WIDTH)) u_alu (
        .op     (op_q),
        .a      (alu_a),
        .b      (b_q),
        .result (alu_res)
    );

`ifdef WASM_STACK_TRAP_EN
    logic [DEPTH_LOG2-1:0] need;
    logic                  full;

    assign full = (stk_depth == {DEPTH_LOG2{1'b1}});

    always_comb begin
        need = '0;
        if (op_q == OP_DROP || op_q == OP_DUP || op_q == OP_EQZ) need = DEPTH_LOG2'(1);
        if (op_q == OP_SWAP || is_binary(op_q))                  need = DEPTH_LOG2'(2);
    end
`endif

    always_ff @(posedge clk) begin
        if (reset) begin
            state            <= IDLE;
            op_q             <= '0;
            imm_q            <= '0;
            a_q              <= '0;
            b_q              <= '0;
            stk_push         <= 1'b0;
            stk_pop          <= 1'b0;
            stk_read_second  <= 1'b0;
            stk_write_top    <= 1'b0;
            stk_write_second <= 1'b0;
            stk_push_data    <= '0;
            stk_write_data   <= '0;
            rsp_valid_q      <= 1'b0;
            rsp_data_q       <= '0;
            trap_q           <= 1'b0;
            trap_code_q      <= TRAP_NONE;
        end else begin
            stk_push         <= 1'b0;
            stk_pop          <= 1'b0;
            stk_read_second  <= 1'b0;
            stk_write_top    <= 1'b0;
            stk_write_second <= 1'b0;
            case (state)
                IDLE: if (bus.cmd_valid) begin
                    op_q  <= bus.cmd_op;
                    imm_q <= bus.cmd_imm;
                    state <= CHECK;
                end
                CHECK: begin
`ifdef WASM_STACK_TRAP_EN
                    if (stk_depth < need) begin
                        state <= RESP; rsp_valid_q <= 1'b1; rsp_data_q <= rsp_top;
                        trap_q <= 1'b1; trap_code_q <= TRAP_UNDERFLOW;
                    end else if (full && (op_q == OP_PUSH || op_q == OP_DUP)) begin
                        state <= RESP; rsp_valid_q <= 1'b1; rsp_data_q <= rsp_top;
                        trap_q <= 1'b1; trap_code_q <= TRAP_OVERFLOW;
                    end else begin
`else
                    begin
`endif
                        case (op_q)
                            OP_NOP: begin
                                state <= RESP; rsp_valid_q <= 1'b1; rsp_data_q <= rsp_top;
                                trap_q <= 1'b0; trap_code_q <= TRAP_NONE;
                            end
                            OP_PUSH: begin
                                state <= PUSH; stk_push <= 1'b1; stk_push_data <= imm_q;
                            end
                            OP_DUP: begin
                                state <= PUSH; stk_push <= 1'b1; stk_push_data <= stk_top_data;
                            end
                            OP_DROP: begin
                                state <= POP; stk_pop <= 1'b1;
                            end
                            OP_EQZ: begin
                                state <= WRTOP; stk_write_top <= 1'b1; stk_write_data <= alu_res;
                            end
                            OP_SWAP, OP_ADD, OP_SUB, OP_AND, OP_OR, OP_XOR: begin
                                state <= RD2; stk_read_second <= 1'b1;
                            end
                            default: begin
                                state <= RESP; rsp_valid_q <= 1'b1; rsp_data_q <= rsp_top;
                                trap_q <= 1'b1; trap_code_q <= TRAP_ILLEGAL;
                            end
                        endcase
                    end
                end
                RD2: state <= WAIT2;
                WAIT2: begin
                    a_q <= stk_second_data;
                    b_q <= stk_top_data;
                    if (op_q == OP_SWAP) begin
                        state <= WR2; stk_write_second <= 1'b1; stk_write_data <= stk_top_data;
                    end else begin
                        state <= POP; stk_pop <= 1'b1;
                    end
                end
                WR2: begin
                    state <= WRTOP; stk_write_top <= 1'b1; stk_write_data <= a_q;
                end
                POP: begin
                    // DROP ends after the pop; binary ops overwrite the new top with the result
                    if (op_q == OP_DROP) begin
                        state <= SETTLE;
                    end else begin
                        state <= WRTOP; stk_write_top <= 1'b1; stk_write_data <= alu_res;
                    end
                end
                WRTOP, PUSH: state <= SETTLE;
                SETTLE: begin
                    state <= RESP; rsp_valid_q <= 1'b1; rsp_data_q <= rsp_top;
                    trap_q <= 1'b0; trap_code_q <= TRAP_NONE;
                end
                RESP: if (bus.rsp_ready) begin
                    state       <= IDLE;
                    rsp_valid_q <= 1'b0;
                    trap_q      <= 1'b0;
                    trap_code_q <= TRAP_NONE;
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: doc/wasm_stack_ctrl.md
WASM_STACK_CTRL -- requirements
Module: wasm_stack_ctrl

Interface
- REQ-001: Parameter DEPTH_LOG2, default 5, SHALL be the log2 of the attached stack size; it must match the stack instance.
- REQ-002: Parameter WIDTH, default 32, SHALL be the data word width.
- REQ-003: clk  in  1  clock; all logic SHALL be on the rising edge.
- REQ-004: reset  in  1  reset, synchronous, active-high.
- REQ-005: cmd_valid in 1, cmd_ready out 1, cmd_op in 4, cmd_imm in WIDTH SHALL form the command handshake; a command transfers when valid && ready.
- REQ-006: rsp_valid out 1, rsp_ready in 1, rsp_data out WIDTH, trap out 1, trap_code out 2 SHALL form the response handshake.
- REQ-007: stk_push, stk_pop, stk_read_second, stk_write_top, stk_write_second out 1; stk_push_data, stk_write_data out WIDTH SHALL drive the stack.
- REQ-008: stk_top_data in WIDTH, stk_second_data in WIDTH, stk_depth in DEPTH_LOG2 SHALL be the stack outputs.

Function
- REQ-009: Opcodes SHALL be 0 NOP, 1 PUSH imm, 2 DROP, 3 DUP, 4 SWAP, 5 ADD, 6 SUB, 7 EQZ, 8 AND, 9 OR, 10 XOR; 11-15 SHALL be illegal.
- REQ-010: States SHALL be IDLE, CHECK, RD2, WAIT2, POP, WR2, WRTOP, PUSH, SETTLE, RESP.
- REQ-011: cmd_ready SHALL be 1 only in IDLE; accepting a command SHALL latch op/imm and go to CHECK.
- REQ-012: At most one stk_* strobe SHALL be high in any cycle, each for exactly one cycle.
- REQ-013: PUSH SHALL be CHECK->PUSH (stk_push, data=imm)->SETTLE->RESP.
- REQ-014: DROP SHALL be CHECK->POP->SETTLE->RESP.
- REQ-015: DUP SHALL be CHECK->PUSH (data=stk_top_data)->SETTLE->RESP.
- REQ-016: EQZ SHALL be CHECK->WRTOP (data=1 if top==0 else 0)->SETTLE->RESP.
- REQ-017: SWAP SHALL be CHECK->RD2->WAIT2 (latch a=second, b=top)->WR2 (data=b)->WRTOP (data=a)->SETTLE->RESP.
- REQ-018: Binary ops SHALL be CHECK->RD2->WAIT2 (latch a=second, b=top)->POP->WRTOP (data=a op b)->SETTLE->RESP; SUB is a-b, modulo 2^WIDTH, with no carry output.
- REQ-019: NOP SHALL be CHECK->RESP with no strobes.
- REQ-020: In RESP, rsp_valid SHALL be 1 with rsp_data=stk_top_data (0 when stk_depth==0), held stable until rsp_ready; then the FSM SHALL return to IDLE.
- REQ-021: An illegal opcode SHALL go CHECK->RESP with no strobes, trap=1, trap_code=3.
- REQ-022: trap/trap_code SHALL be 0 on non-trapping responses.
- REQ-023: Full SHALL mean stk_depth == 2**DEPTH_LOG2-1.

Reset
- REQ-024: On reset, state SHALL be IDLE; all strobes, rsp_valid, trap, trap_code, rsp_data and the latched a/b/op/imm SHALL be 0.
- REQ-025: Reset mid-operation SHALL drop all strobes on the next cycle and discard the in-flight command with no response; the stack SHALL be reset by the same signal.
- REQ-026: cmd_ready SHALL be 0 while reset is asserted and 1 in the first cycle after reset deasserts.

Configuration
- REQ-027: With WASM_STACK_TRAP_EN defined, CHECK SHALL trap without strobes when depth is insufficient.
  - Underflow (trap_code=1): depth<1 for DROP/DUP/EQZ; depth<2 for SWAP/binary.
  - Overflow (trap_code=2): full for PUSH/DUP.
  - Underflow SHALL take priority.
- REQ-028: Without WASM_STACK_TRAP_EN, depth SHALL NOT be checked, trap_code 1/2 SHALL never occur, and the stack SHALL wrap naturally.

Structure
- REQ-029: Package wasm_stack_pkg SHALL hold the opcode constants, the trap_code constants and the state enumeration.
- REQ-030: A combinational sub-module wasm_stack_alu (op, a, b -> result) SHALL implement ADD/SUB/EQZ/AND/OR/XOR.

Verification
- REQ-031: The bench SHALL cover, against a real stack instance, each scenario below:
  - PUSH 5, PUSH 7, ADD -> responses rsp_data 5, 7, 12; final depth 1.
  - PUSH 3, PUSH 10, SUB -> rsp_data 0xFFFFFFF9 (3-10); PUSH 1, PUSH 2, SWAP -> top 1, second 2.
  - Empty stack, DROP with TRAP_EN -> trap=1, trap_code=1, no strobe seen, depth stays 0; PUSH 31 times then DUP -> trap_code=2.
  - cmd_op=12 -> trap=1, trap_code=3 in either build; rsp_ready held low 5 cycles -> rsp_valid and rsp_data stable throughout, cmd_ready=0.
  - Reset asserted during WAIT2 of ADD -> next cycle all strobes 0, no rsp_valid, cmd_ready=1 after release; the one-hot strobe assertion SHALL hold throughout the run.
